// File: rtl/apb_master_ctrl.sv
// APB requester: takes single read/write commands on valid/ready, runs SETUP/ACCESS,
// and returns read data or a timeout error as a one-cycle response pulse.
module apb_master_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PRWADDR,
    output logic [DATA_W-1:0] PRWDATA,
    input  logic [DATA_W-1:0] PRWDATA1,
    input  logic              PREADY
);

    // A zero TIMEOUT still needs a 1-bit counter; it saturates instead of wrapping.
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PRWADDR   <= '0;
            PRWDATA   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        PWRITE    <= cmd_write;
                        PRWADDR   <= cmd_addr;
                        PRWDATA   <= cmd_wdata;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata <= PWRITE ? '0 : PRWDATA1;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= RESP;
                    end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= RESP;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    wait_cnt  <= '0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: a cycle-driven slave model plus a response scoreboard.
module tb_apb_master_ctrl;

    localparam int TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PRWADDR, PRWDATA, PRWDATA1;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];
    int low_run  = 0;
    int last_gap = 0;

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PRWADDR(PRWADDR), .PRWDATA(PRWDATA), .PRWDATA1(PRWDATA1), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Length of the PSEL-low stretch preceding each new SETUP.
    always @(negedge PCLK) begin
        if (PSEL !== 1'b1) low_run++;
        else begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command: waits = ACCESS cycles with PREADY low before it rises.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic [31:0] rd,
                        input logic setup_rdy, input logic keep_valid,
                        output int psel_n, output int pen_n, output int lat);
        int guard;
        int acc;
        int stab_bad;
        int rdy_bad;
        logic done;
        logic exp_err;
        logic [31:0] exp_rd;
        psel_n = 0; pen_n = 0; lat = 0; acc = 0; stab_bad = 0; rdy_bad = 0; done = 1'b0;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        chk({tag, "_ready"}, 64'(guard < 20), 64'd1);
        exp_err = (waits >= TO);
        exp_rd  = (wr || exp_err) ? 32'h0 : rd;
        exp_q.push_back({exp_err, exp_rd});
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        PREADY = setup_rdy;
        @(posedge PCLK);
        @(negedge PCLK);
        if (keep_valid) begin
            cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
        end else begin
            cmd_valid = 1'b0;
        end
        for (guard = 0; guard < 40 && !done; guard++) begin
            lat++;
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
                if (PSEL !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b0) rdy_bad++;
                if (exp_q.size() == 0) chk({tag, "_unexpected_rsp"}, 64'd1, 64'd0);
                else chk({tag, "_rsp"}, 64'({rsp_err, rsp_rdata}), 64'(exp_q.pop_front()));
            end else begin
                if (PSEL === 1'b1) psel_n++;
                if (PENABLE === 1'b1) pen_n++;
                if (PSEL === 1'b1 && (PWRITE !== wr || PRWADDR !== addr || PRWDATA !== wdata))
                    stab_bad++;
                if (cmd_ready !== 1'b0) rdy_bad++;
                if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                    PREADY   = (acc >= waits);
                    PRWDATA1 = PREADY ? rd : 32'hDEAD_BEEF;
                    acc++;
                end else begin
                    PREADY   = setup_rdy;
                    PRWDATA1 = 32'hDEAD_BEEF;
                end
                @(negedge PCLK);
            end
        end
        PREADY = 1'b0;
        chk({tag, "_rsp_seen"}, 64'(done), 64'd1);
        chk({tag, "_apb_stable"}, 64'(stab_bad), 64'd0);
        chk({tag, "_busy_not_ready"}, 64'(rdy_bad), 64'd0);
    endtask

    initial begin
        int ps, pe, lt, rv;
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PREADY = 1'b0; PRWDATA1 = '0;
        repeat (2) @(negedge PCLK);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_apb", 64'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}), 64'd0);
        chk("rst_addr_data", 64'({PRWADDR, PRWDATA}), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);

        // Write 0x4 <- 0xA, slave answers one ACCESS cycle late.
        xfer("t1", 1'b1, 32'h4, 32'h0000_000A, 1, 32'h0, 1'b0, 1'b0, ps, pe, lt);
        chk("t1_psel_cycles", 64'(ps), 64'd3);
        chk("t1_pen_cycles", 64'(pe), 64'd2);
        chk("t1_latency", 64'(lt), 64'd4);
        repeat (3) @(negedge PCLK);
        chk("t1_idle_hold", 64'({PWRITE, PRWADDR, PRWDATA}), 64'({1'b1, 32'h4, 32'hA}));
        chk("t1_rsp_hold", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);

        // Zero-wait read of 0x4 returning 9.
        xfer("t2", 1'b0, 32'h4, 32'h0, 0, 32'h0000_0009, 1'b0, 1'b0, ps, pe, lt);
        chk("t2_latency", 64'(lt), 64'd3);
        chk("t2_pen_cycles", 64'(pe), 64'd1);
        @(negedge PCLK);
        chk("t2_rdata_hold", 64'({rsp_err, rsp_rdata}), 64'h9);

        // PREADY never rises: aborts after exactly TO ACCESS cycles.
        xfer("t3", 1'b0, 32'h8, 32'h0, 1000, 32'h1234_5678, 1'b0, 1'b0, ps, pe, lt);
        chk("t3_access_cycles", 64'(pe), 64'(TO));
        chk("t3_psel_cycles", 64'(ps), 64'(TO + 1));
        @(negedge PCLK);
        chk("t3_psel_low", 64'({PSEL, PENABLE}), 64'd0);

        // Timeout boundary: PREADY on the last allowed ACCESS cycle wins.
        xfer("t3b", 1'b0, 32'hC, 32'h0, TO - 1, 32'h0000_00C3, 1'b0, 1'b0, ps, pe, lt);
        chk("t3b_access_cycles", 64'(pe), 64'(TO));

        // cmd_valid held high across two commands with changing cmd_* during the first.
        xfer("t4a", 1'b1, 32'h4, 32'h0000_0011, 0, 32'h0, 1'b0, 1'b1, ps, pe, lt);
        xfer("t4b", 1'b0, 32'h4, 32'h0, 0, 32'h0000_0022, 1'b0, 1'b0, ps, pe, lt);
        total++;
        assert (last_gap >= 2) else begin
            bad++;
            $error("FAIL t4_psel_gap observed=%0d expected>=2", last_gap);
        end

        // High PREADY during SETUP must not shorten the transfer.
        xfer("t6", 1'b0, 32'h4, 32'h0, 1, 32'h0000_0066, 1'b1, 1'b0, ps, pe, lt);
        chk("t6_psel_cycles", 64'(ps), 64'd3);
        chk("t6_access_cycles", 64'(pe), 64'd2);

        // Reset in the middle of ACCESS.
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; PREADY = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("t5_in_access", 64'({PSEL, PENABLE}), 64'b11);
        #2 PRESETn = 1'b0;
        #1;
        chk("t5_drop", 64'({PSEL, PENABLE, rsp_valid, cmd_ready}), 64'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        chk("t5_ready_after_release", 64'(cmd_ready), 64'd1);
        rv = 0;
        repeat (4) begin
            @(negedge PCLK);
            if (rsp_valid !== 1'b0 || PSEL !== 1'b0) rv++;
        end
        chk("t5_no_rsp", 64'(rv), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
